memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 14 +
 rtl/memory_arbiter_watchdog.sv | 38 +++
 rtl/memory_arbiter.sv | 123 ++++++++++++
 tb/tb_memory_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter and its watchdog.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arbState_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 2;
  localparam int unsigned TIMEOUT_DEFAULT      = 15;
  localparam logic [31:0] ABORT_FILL           = 32'hDEADBEEF;

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// Counts cycles an outstanding memory request has waited; expire fires on the
// cycle that would complete the TIMEOUT-th waiting cycle.
module arb_watchdog
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expire_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, with
// bounded data priority over a waiting fetch and a watchdog abort.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        timeout_err_o
);

  localparam int unsigned SW         = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arbState_e   state_q;
  logic [SW-1:0] starveCnt_q;
  logic        ifReady_q, dmReady_q, memReq_q, memWe_q, timeoutErr_q;
  logic [31:0] memAddr_q, memWdata_q, ifRdata_q, dmRdata_q;
  logic        ifElig, dmElig, grantDm, expire;

  // A requester whose ready is high this cycle has just been served and must
  // not be granted again on the strength of the same held request.
  assign ifElig  = if_req_i && !ifReady_q;
  assign dmElig  = dm_req_i && !dmReady_q;
  assign grantDm = dmElig && ((starveCnt_q < STARVE_MAX) || !ifElig);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (memReq_q),
    .clear_i  (!memReq_q || mem_ack_i),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      starveCnt_q  <= '0;
      ifReady_q    <= 1'b0;
      dmReady_q    <= 1'b0;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      ifRdata_q    <= '0;
      dmRdata_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      ifReady_q <= 1'b0;
      dmReady_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grantDm) begin
            state_q    <= BUSY_DM;
            memReq_q   <= 1'b1;
            memWe_q    <= dm_we_i;
            memAddr_q  <= dm_addr_i;
            memWdata_q <= dm_wdata_i;
            if (ifElig && (starveCnt_q < STARVE_MAX)) begin
              starveCnt_q <= starveCnt_q + SW'(1);
            end
          end else if (ifElig) begin
            state_q     <= BUSY_IF;
            memReq_q    <= 1'b1;
            memWe_q     <= 1'b0;
            memAddr_q   <= if_addr_i;
            memWdata_q  <= '0;
            starveCnt_q <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          // An ack on the expiry cycle still wins; abort only when none came.
          if (mem_ack_i || expire) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
            if (!mem_ack_i) begin
              timeoutErr_q <= 1'b1;
            end
            if (state_q == BUSY_IF) begin
              ifReady_q <= 1'b1;
              ifRdata_q <= mem_ack_i ? mem_rdata_i : ABORT_FILL;
            end else begin
              dmReady_q <= 1'b1;
              if (!memWe_q) begin
                dmRdata_q <= mem_ack_i ? mem_rdata_i : ABORT_FILL;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata_o    = ifRdata_q;
  assign if_ready_o    = ifReady_q;
  assign dm_rdata_o    = dmRdata_q;
  assign dm_ready_o    = dmReady_q;
  assign mem_req_o     = memReq_q;
  assign mem_we_o      = memWe_q;
  assign mem_addr_o    = memAddr_q;
  assign mem_wdata_o   = memWdata_q;
  assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural reference model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 2;
  localparam int TIMEOUT      = 15;
  localparam int OWN_NONE = 0, OWN_IF = 1, OWN_DM = 2;
  localparam int MODE_OFF = 0, MODE_ONCE = 1, MODE_HOLD = 2, MODE_RAND = 3;
  localparam int ACK_RAND = -1, ACK_NEVER = -2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        ifReq, dmReq, dmWe, memAck;
  logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [31:0] ifRdataO, dmRdataO, memAddrO, memWdataO;
  logic        ifReadyO, dmReadyO, memReqO, memWeO, timeoutErrO;

  always #5 clk = ~clk;

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_rdata_o(ifRdataO), .if_ready_o(ifReadyO),
    .dm_req_i(dmReq), .dm_we_i(dmWe), .dm_addr_i(dmAddr), .dm_wdata_i(dmWdata),
    .dm_rdata_o(dmRdataO), .dm_ready_o(dmReadyO),
    .mem_req_o(memReqO), .mem_we_o(memWeO), .mem_addr_o(memAddrO), .mem_wdata_o(memWdataO),
    .mem_rdata_i(memRdata), .mem_ack_i(memAck), .timeout_err_o(timeoutErrO)
  );

  int testCount = 0;
  int failCount = 0;
  int ifMode, dmMode, ackMode, ackCnt, ackLat;
  bit spurious, forceAck, ackDataFixed, prevMemReq;
  logic [31:0] ackData;

  int mOwner, mStarve, mWait;
  bit eIfReady, eDmReady, eMemReq, eMemWe, eTerr;
  logic [31:0] eMemAddr, eMemWdata, eIfRdata, eDmRdata;
  int modelGrants[$];
  int dutGrants[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] randIfAddr();
    logic [28:0] r = 29'($urandom);
    return {1'b0, r, 2'b00};
  endfunction

  function automatic logic [31:0] randDmAddr();
    logic [28:0] r = 29'($urandom);
    return {1'b1, r, 2'b00};
  endfunction

  task automatic modelReset();
    mOwner = OWN_NONE; mStarve = 0; mWait = 0;
    eIfReady = 0; eDmReady = 0; eMemReq = 0; eMemWe = 0; eTerr = 0;
    eMemAddr = '0; eMemWdata = '0; eIfRdata = '0; eDmRdata = '0;
    prevMemReq = 0; ackCnt = 0;
  endtask

  // Predicts the outputs after the coming edge from the inputs now driven.
  task automatic modelStep();
    bit ifElig, dmElig, done;
    logic [31:0] data;
    ifElig = ifReq && !eIfReady;
    dmElig = dmReq && !eDmReady;
    eIfReady = 0;
    eDmReady = 0;
    done = 0;
    data = '0;
    if (mOwner == OWN_NONE) begin
      if (dmElig && (mStarve < STARVE_LIMIT || !ifElig)) begin
        mOwner = OWN_DM; eMemWe = dmWe; eMemAddr = dmAddr; eMemWdata = dmWdata;
        if (ifElig) mStarve = (mStarve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mStarve + 1;
      end else if (ifElig) begin
        mOwner = OWN_IF; eMemWe = 0; eMemAddr = ifAddr; mStarve = 0;
      end
      if (mOwner != OWN_NONE) begin
        modelGrants.push_back(mOwner);
        eMemReq = 1;
        mWait = 0;
      end
    end else begin
      if (memAck) begin
        data = memRdata; done = 1;
      end else if (mWait + 1 >= TIMEOUT) begin
        data = ABORT_FILL; done = 1; eTerr = 1;
      end else begin
        mWait++;
      end
      if (done) begin
        eMemReq = 0;
        if (mOwner == OWN_IF) begin
          eIfReady = 1; eIfRdata = data;
        end else begin
          eDmReady = 1;
          if (!eMemWe) eDmRdata = data;
        end
        mOwner = OWN_NONE;
      end
    end
  endtask

  task automatic driveInputs();
    if (ifReq && ifReadyO) begin
      if (ifMode == MODE_HOLD) ifAddr = randIfAddr();
      else ifReq = 0;
    end else if (!ifReq && (ifMode == MODE_HOLD || (ifMode == MODE_RAND && $urandom_range(0, 2) == 0))) begin
      ifReq = 1; ifAddr = randIfAddr();
    end
    if (dmReq && dmReadyO) begin
      if (dmMode == MODE_HOLD) begin
        dmAddr = randDmAddr(); dmWe = 1'($urandom); dmWdata = $urandom;
      end else dmReq = 0;
    end else if (!dmReq && (dmMode == MODE_HOLD || (dmMode == MODE_RAND && $urandom_range(0, 2) == 0))) begin
      dmReq = 1; dmAddr = randDmAddr(); dmWe = 1'($urandom); dmWdata = $urandom;
    end
    if (forceAck) begin
      memAck = 1; memRdata = $urandom;
    end else if (!memReqO) begin
      ackCnt = 0; memAck = spurious && ($urandom_range(0, 3) == 0); memRdata = $urandom;
    end else if (ackMode == ACK_NEVER) begin
      memAck = 0;
    end else begin
      if (ackCnt == 0) ackLat = (ackMode == ACK_RAND) ? int'($urandom_range(0, 3)) : ackMode;
      memAck = (ackCnt >= ackLat);
      memRdata = ackDataFixed ? ackData : $urandom;
      ackCnt++;
    end
  endtask

  task automatic checkCycle();
    checkOutput("if_ready", 32'(ifReadyO), 32'(eIfReady));
    checkOutput("dm_ready", 32'(dmReadyO), 32'(eDmReady));
    checkOutput("mem_req", 32'(memReqO), 32'(eMemReq));
    checkOutput("timeout_err", 32'(timeoutErrO), 32'(eTerr));
    checkOutput("if_rdata", ifRdataO, eIfRdata);
    checkOutput("dm_rdata", dmRdataO, eDmRdata);
    if (eMemReq) begin
      checkOutput("mem_we", 32'(memWeO), 32'(eMemWe));
      checkOutput("mem_addr", memAddrO, eMemAddr);
      if (eMemWe) checkOutput("mem_wdata", memWdataO, eMemWdata);
    end
    if (memReqO && !prevMemReq) dutGrants.push_back(memAddrO[31] ? OWN_DM : OWN_IF);
    prevMemReq = memReqO;
  endtask

  task automatic applyStimulus();
    driveInputs();
    modelStep();
    @(posedge clk);
    #1;
    checkCycle();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_if_ready"}, 32'(ifReadyO), 32'd0);
    checkOutput({tag, "_dm_ready"}, 32'(dmReadyO), 32'd0);
    checkOutput({tag, "_mem_req"}, 32'(memReqO), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(memWeO), 32'd0);
    checkOutput({tag, "_mem_addr"}, memAddrO, 32'd0);
    checkOutput({tag, "_mem_wdata"}, memWdataO, 32'd0);
    checkOutput({tag, "_if_rdata"}, ifRdataO, 32'd0);
    checkOutput({tag, "_dm_rdata"}, dmRdataO, 32'd0);
    checkOutput({tag, "_timeout_err"}, 32'(timeoutErrO), 32'd0);
  endtask

  task automatic compareGrants(input string tag);
    checkOutput({tag, "_grant_count"}, 32'(dutGrants.size()), 32'(modelGrants.size()));
    for (int i = 0; i < dutGrants.size() && i < modelGrants.size(); i++)
      checkOutput($sformatf("%s_grant%0d", tag, i), 32'(dutGrants[i]), 32'(modelGrants[i]));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 100000ns");
    $fatal(1, "[TB] global time limit exceeded");
  end

  initial begin
    int readyCnt, reqCycles, run, maxRun, ifGrants;
    bit seen;
    ifReq = 0; ifAddr = '0; dmReq = 0; dmWe = 0; dmAddr = '0; dmWdata = '0;
    memAck = 0; memRdata = '0; ackLat = 0; ackData = '0;
    ifMode = MODE_OFF; dmMode = MODE_OFF; ackMode = ACK_RAND;
    spurious = 0; forceAck = 0; ackDataFixed = 0;
    rstN = 1;
    #2 rstN = 0;
    #1 modelReset();
    checkResetState("reset");
    repeat (2) @(posedge clk);
    #1 rstN = 1;

    // Single fetch, ack two cycles after mem_req.
    ifMode = MODE_ONCE; ifReq = 1; ifAddr = 32'h40;
    ackMode = 2; ackDataFixed = 1; ackData = 32'h8C010004;
    readyCnt = 0; seen = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      readyCnt += int'(ifReadyO);
      if (memReqO && memAddrO == 32'h40 && !memWeO) seen = 1;
    end
    checkOutput("fetch_ready_pulses", 32'(readyCnt), 32'd1);
    checkOutput("fetch_mem_addr", 32'(seen), 32'd1);
    checkOutput("fetch_rdata", ifRdataO, 32'h8C010004);

    // A load to give dm_rdata a known value, then a store that must keep it.
    dmMode = MODE_ONCE; dmReq = 1; dmWe = 0; dmAddr = 32'h200;
    ackMode = 1; ackData = 32'hA5A55A5A;
    repeat (6) applyStimulus();
    checkOutput("load_rdata", dmRdataO, 32'hA5A55A5A);
    dmReq = 1; dmWe = 1; dmAddr = 32'h100; dmWdata = 32'h12345678;
    readyCnt = 0; seen = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      readyCnt += int'(dmReadyO);
      if (memReqO && memWeO && memAddrO == 32'h100 && memWdataO == 32'h12345678) seen = 1;
    end
    checkOutput("store_ready_pulses", 32'(readyCnt), 32'd1);
    checkOutput("store_mem_fields", 32'(seen), 32'd1);
    checkOutput("store_keeps_rdata", dmRdataO, 32'hA5A55A5A);

    // Both ports held with zero-latency acks; the served port sits out one
    // idle cycle, so grant order follows the eligibility and starve rules.
    modelGrants.delete(); dutGrants.delete();
    ifMode = MODE_HOLD; dmMode = MODE_HOLD; ackMode = 0; ackDataFixed = 0;
    repeat (40) applyStimulus();
    ifMode = MODE_OFF; dmMode = MODE_OFF;
    repeat (10) applyStimulus();
    compareGrants("contention");
    run = 0; maxRun = 0; ifGrants = 0;
    foreach (dutGrants[i]) begin
      if (dutGrants[i] == OWN_DM) run++;
      else begin run = 0; ifGrants++; end
      if (run > maxRun) maxRun = run;
    end
    checkOutput("contention_dm_run_bounded", 32'(maxRun <= STARVE_LIMIT), 32'd1);
    checkOutput("contention_fetch_served", 32'(ifGrants > 0), 32'd1);

    // Random traffic, random latency, spurious acks while idle.
    modelGrants.delete(); dutGrants.delete();
    ifMode = MODE_RAND; dmMode = MODE_RAND; ackMode = ACK_RAND; spurious = 1;
    repeat (300) applyStimulus();
    ifMode = MODE_OFF; dmMode = MODE_OFF; spurious = 0;
    repeat (15) applyStimulus();
    compareGrants("random");

    // Load that is never acknowledged.
    ackMode = ACK_NEVER; dmMode = MODE_ONCE; dmReq = 1; dmWe = 0; dmAddr = 32'h8000_0300;
    readyCnt = 0; reqCycles = 0;
    for (int c = 0; c < 25; c++) begin
      applyStimulus();
      readyCnt += int'(dmReadyO);
      reqCycles += int'(memReqO);
    end
    checkOutput("timeout_req_cycles", 32'(reqCycles), 32'(TIMEOUT));
    checkOutput("timeout_ready_pulses", 32'(readyCnt), 32'd1);
    checkOutput("timeout_rdata", dmRdataO, 32'hDEADBEEF);
    checkOutput("timeout_err_set", 32'(timeoutErrO), 32'd1);
    forceAck = 1; readyCnt = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      readyCnt += int'(dmReadyO);
    end
    forceAck = 0;
    checkOutput("late_ack_ignored", 32'(readyCnt), 32'd0);
    checkOutput("timeout_err_sticky", 32'(timeoutErrO), 32'd1);

    // Reset while a data load is outstanding, then a fresh load.
    dmReq = 1; dmWe = 0; dmAddr = 32'h8000_0400;
    repeat (3) applyStimulus();
    checkOutput("busy_before_reset", 32'(memReqO), 32'd1);
    #2 rstN = 0;
    #1 modelReset();
    checkResetState("midreset");
    readyCnt = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 readyCnt += int'(dmReadyO);
    end
    checkOutput("midreset_no_ready", 32'(readyCnt), 32'd0);
    rstN = 1;
    ackMode = 1; ackDataFixed = 1; ackData = 32'h0BADF00D;
    readyCnt = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      readyCnt += int'(dmReadyO);
    end
    checkOutput("after_reset_ready_pulses", 32'(readyCnt), 32'd1);
    checkOutput("after_reset_rdata", dmRdataO, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
